// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and writeback.
// Computes the effective address and issues lane-aligned load/store requests
// to a variable-latency SRAM port. Aligns and extends load data, and flags
// misaligned or illegal accesses. Results return in program order through an
// in-order completion queue, paired with a response FIFO for load data.
module load_store_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [2:0]           in_funct3,
    input  logic [XLEN-1:0]      in_base,
    input  logic [XLEN-1:0]      in_offset,
    input  logic [XLEN-1:0]      in_wdata,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_data,
    output logic [XLEN-1:0]      out_addr,
    output logic                 out_misaligned,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 mem_req,
    input  logic                 mem_gnt,
    output logic                 mem_we,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN/8-1:0]    mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Request-side decode
    op_e             in_kind;
    logic [XLEN-1:0] ea;
    logic [OFFW-1:0] off;
    logic [3:0]      size_b;
    logic            is_load;
    logic            is_store;
    logic            legal;
    logic            misaligned;
    logic            space;
    logic            accept;
    logic            pop;
    logic [NB-1:0]   be_base;

    // Completion queue
    op_e             q_kind  [DEPTH];
    logic [2:0]      q_f3    [DEPTH];
    logic [OFFW-1:0] q_off   [DEPTH];
    logic [XLEN-1:0] q_ea    [DEPTH];
    logic            q_mis   [DEPTH];
    logic            q_ld    [DEPTH];
    logic [TAG_WIDTH-1:0] q_tag [DEPTH];
    logic [XLEN-1:0] q_wdata [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Load response FIFO and issued-but-unanswered load counter
    logic [XLEN-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   outstanding;
    logic            issue_ld;
    logic            resp_take;
    logic            head_ld;

    // Head result formatting
    logic [XLEN-1:0] head_sh;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] ext;
    int unsigned     nbits;
    logic            sign;

    // Decode incoming op: address, access size, legality and alignment
    always_comb begin
        in_kind  = op_e'(in_op);
        ea       = in_base + in_offset;
        off      = ea[OFFW-1:0];
        size_b   = 4'd1 << in_funct3[1:0];
        is_load  = (in_kind == OP_LOAD);
        is_store = (in_kind == OP_STORE);
        legal    = 1'b0;
        if (is_load) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = (XLEN == 64);
                default:                                legal = 1'b0;
            endcase
        end else if (is_store) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                3'b011:                 legal = (XLEN == 64);
                default:                legal = 1'b0;
            endcase
        end
        misaligned = (is_load || is_store) &&
                     (!legal || ((4'(off) & (size_b - 4'd1)) != 4'd0));
    end

    // Memory request, upstream handshake and lane formatting
    always_comb begin
        space    = (count < CW'(DEPTH));
        mem_req  = rst_n && in_valid && space && (is_load || is_store) && !misaligned;
        in_ready = rst_n && space && (!mem_req || mem_gnt);
        accept   = in_valid && in_ready;
        issue_ld = mem_req && mem_gnt && is_load;
        mem_we   = is_store;
        mem_addr = {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
        be_base  = ~({NB{1'b1}} << size_b);
        mem_be   = be_base << off;
        case (in_funct3[1:0])
            2'd0:    mem_wdata = {NB{in_wdata[7:0]}};
            2'd1:    mem_wdata = {(NB/2){in_wdata[15:0]}};
            2'd2:    mem_wdata = {(NB/4){in_wdata[31:0]}};
            default: mem_wdata = in_wdata;
        endcase
    end

    // Capture accepted op into the completion queue slot at the write pointer
    always_ff @(posedge clk) begin
        if (accept) begin
            q_kind[wr_ptr]  <= (in_kind == OP_RSVD) ? OP_NONE : in_kind;
            q_f3[wr_ptr]    <= in_funct3;
            q_off[wr_ptr]   <= off;
            q_ea[wr_ptr]    <= ea;
            q_mis[wr_ptr]   <= misaligned;
            q_ld[wr_ptr]    <= is_load && !misaligned;
            q_tag[wr_ptr]   <= in_tag;
            q_wdata[wr_ptr] <= in_wdata;
        end
    end

    // Completion queue pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Responses only count against loads actually issued since reset
    always_comb begin
        resp_take = mem_rvalid && (outstanding != '0);
        head_ld   = q_ld[rd_ptr];
        out_valid = (count != '0) && (!head_ld || (r_count != '0));
        pop       = out_valid && out_ready;
    end

    // Store accepted load data into the response FIFO
    always_ff @(posedge clk) begin
        if (resp_take) r_data[r_wr] <= mem_rdata;
    end

    // Response FIFO pointers and outstanding-load counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            outstanding <= '0;
        end else begin
            if (resp_take)       r_wr <= r_wr + 1'b1;
            if (pop && head_ld)  r_rd <= r_rd + 1'b1;
            case ({resp_take, pop && head_ld})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case ({issue_ld, resp_take})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Format the head op's result: lane-align, truncate and extend load data
    always_comb begin
        head_sh = r_data[r_rd] >> {q_off[rd_ptr], 3'b000};
        nbits   = 32'd8 << q_f3[rd_ptr][1:0];
        keep    = (nbits >= XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
        case (q_f3[rd_ptr][1:0])
            2'd0:    sign = head_sh[7];
            2'd1:    sign = head_sh[15];
            2'd2:    sign = head_sh[31];
            default: sign = head_sh[XLEN-1];
        endcase
        ext = (head_sh & keep) | ((sign && !q_f3[rd_ptr][2]) ? ~keep : '0);

        out_data       = '0;
        out_addr       = q_ea[rd_ptr];
        out_misaligned = q_mis[rd_ptr];
        out_tag        = q_tag[rd_ptr];
        case (q_kind[rd_ptr])
            OP_NONE: begin
                out_data = q_wdata[rd_ptr];
                out_addr = '0;
            end
            OP_LOAD:  out_data = q_mis[rd_ptr] ? '0 : ext;
            default:  out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus randomized traffic.
// A driver computes expected results from a behavioural model at accept time
// and queues them. A monitor pops and compares them when results leave the DUT.
module tb_load_store_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int TW    = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_base, in_offset, in_wdata;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data, out_addr;
    logic            out_misaligned;
    logic [TW-1:0]   out_tag;
    logic            mem_req, mem_gnt, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic [XLEN/8-1:0] mem_be;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    load_store_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_funct3(in_funct3),
        .in_base(in_base), .in_offset(in_offset), .in_wdata(in_wdata), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_misaligned(out_misaligned), .out_tag(out_tag),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        mis;
        logic [7:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          due;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t mem_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    bit   stall  = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: what the stage must produce for one op, by byte arithmetic
    function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                  input logic [31:0] ea, input logic [31:0] wdata,
                                  input logic [31:0] rdata,
                                  output logic mis, output logic [31:0] data,
                                  output logic [31:0] addr, output logic [3:0] be,
                                  output logic [31:0] wrep);
        int size = 1 << f3[1:0];
        int off  = int'(ea % 4);
        bit ls   = (op == 2'd1) || (op == 2'd2);
        bit legal;
        longint unsigned v;
        if (op == 2'd1) legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        else            legal = f3 inside {3'd0, 3'd1, 3'd2};
        mis  = ls && (!legal || (off % size) != 0);
        addr = ls ? ea : 32'd0;
        for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + size);
        for (int j = 0; j < 4; j++) wrep[8*j +: 8] = 8'(wdata >> (8 * (j % size)));
        if (!ls) begin
            data = wdata;
        end else if (op == 2'd2 || mis) begin
            data = 32'd0;
        end else begin
            v = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
            if (!f3[2] && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
            data = v[31:0];
        end
    endfunction

    // Present one op until accepted; expected result is queued at accept
    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] offset, input logic [31:0] wdata,
                         input logic [7:0] tag, input logic [31:0] rdata, input int delay);
        logic [31:0] ea, data, addr, wrep;
        logic [3:0]  be;
        logic        mis;
        bit          ls_ok, space, accepted;
        int          n;
        ea = base + offset;
        model(op, f3, ea, wdata, rdata, mis, data, addr, be, wrep);
        ls_ok = (op == 2'd1 || op == 2'd2) && !mis;
        accepted = 0;
        n = 0;
        while (!accepted) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = op; in_funct3 = f3; in_base = base;
            in_offset = offset; in_wdata = wdata; in_tag = tag;
            mem_gnt = ($urandom_range(0, 2) != 0);
            #1;
            space = exp_q.size() < DEPTH;
            check("mem_req", mem_req, space && ls_ok);
            if (mem_req) begin
                check("mem_addr", mem_addr, ea & 32'hFFFF_FFFC);
                check("mem_be", mem_be, be);
                check("mem_we", mem_we, op == 2'd2);
                if (op == 2'd2) check("mem_wdata", mem_wdata, wrep);
            end
            check("in_ready", in_ready, space && (!(space && ls_ok) || mem_gnt));
            if (in_ready) begin
                accepted = 1;
                exp_q.push_back('{data, addr, mis, tag});
                if (op == 2'd1 && !mis) mem_q.push_back('{rdata, cycle + 1 + delay});
            end
            n++;
            if (!accepted && n > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mem_gnt  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size() + mem_q.size(), 0);
    endtask

    // Memory model: returns granted load data in order after its delay
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_q.size() != 0 && mem_q[0].due <= cycle) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_q.pop_front().rdata;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
        end
    end

    // Monitor: pop expected result whenever the DUT hands one over
    initial begin
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            #2;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {out_tag, out_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_addr", out_addr, e.addr);
                    check("out_mis_tag", {out_misaligned, out_tag}, {e.mis, e.tag});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_funct3 = '0; in_base = '0;
        in_offset = '0; in_wdata = '0; in_tag = '0; mem_gnt = 1'b0;

        // Reset state, with a legal load presented
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd1; in_funct3 = 3'd2; mem_gnt = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_req", mem_req, 0);
        in_valid = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        issue(2'd1, 3'd0, 32'h1000, 32'h3, 32'h0, 8'h10, 32'h80FF_FF12, 1);   // LB
        issue(2'd2, 3'd1, 32'h2000, 32'h2, 32'hABCD, 8'h11, 32'h0, 0);      // SH
        issue(2'd1, 3'd2, 32'h1000, 32'h1, 32'h0, 8'h12, 32'h0, 0);         // LW misaligned
        issue(2'd1, 3'd2, 32'h3000, 32'h4, 32'h0, 8'h01, 32'h1234_5678, 3); // load then none
        issue(2'd0, 3'd0, 32'h0, 32'h0, 32'h55, 8'h02, 32'h0, 0);
        issue(2'd1, 3'd3, 32'h1000, 32'h0, 32'h0, 8'h13, 32'h0, 0);         // LD on 32-bit
        issue(2'd3, 3'd0, 32'h1000, 32'h8, 32'h77, 8'h14, 32'h0, 0);        // reserved
        drain();

        // Full queue: no pops, DEPTH accepts, then blocked
        stall = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++)
            issue(2'd0, 3'd0, 32'h0, 32'h0, 32'h100 + i, 8'h20 + 8'(i), 32'h0, 0);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd0; in_wdata = 32'h999; in_tag = 8'h30;
        #1;
        check("full_in_ready", in_ready, 0);
        in_valid = 1'b0;
        stall = 1'b0;
        issue(2'd0, 3'd0, 32'h0, 32'h0, 32'h999, 8'h30, 32'h0, 0);
        drain();

        // Reset with two loads outstanding; late responses must be dropped
        issue(2'd1, 3'd2, 32'h5000, 32'h0, 32'h0, 8'h40, $urandom, 18);
        issue(2'd1, 3'd4, 32'h5000, 32'h1, 32'h0, 8'h41, $urandom, 18);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #3;
            check("post_rst_out_valid", out_valid, 0);
        end
        check("late_rsp_consumed", mem_q.size(), 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  32'h4000 + $urandom_range(0, 255), 32'($urandom_range(0, 15)) - 32'd8,
                  $urandom, 8'($urandom), $urandom, $urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
